i2c_master: RTL and testbench

- Single-master I2C controller. It is the initiator counterpart to the team's I2C slave device.
- Runs one-byte transactions: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
- Used on the test board to drive the slave device's SCL/SDA pins: writes switch patterns and reads back the stored byte for display on the LEDs.
- Generates SCL from the system clock. No clock stretching, no multi-master arbitration.

---
 rtl/i2c_master.sv | 208 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C initiator running one-byte transactions
// (START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP).
// SCL is generated from i_clk; each bit slot is four quarters of CLK_DIV
// cycles each. No clock stretching, no arbitration.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    synchronous active-low reset
//   i_start    one-cycle request, accepted only while o_busy=0
//   i_addr     7-bit target address, captured on accept
//   i_rw       0=write, 1=read, captured on accept
//   i_wrdata   write byte, captured on accept
//   o_scl      SCL, push-pull, idle high
//   io_sda     SDA, open-drain (drives 0 or high-Z only)
//   o_busy     high from accept until the cycle o_done pulses
//   o_done     one-cycle pulse at transaction end
//   o_ack_err  address or write-data NACK, valid with o_done, held to next accept
//   o_rddata   last byte read, updated only on a successful read
module i2c_master #(
  parameter int CLK_DIV = 125
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [6:0] i_addr,
  input  logic       i_rw,
  input  logic [7:0] i_wrdata,
  output logic       o_scl,
  inout  wire        io_sda,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic [7:0] o_rddata
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK, S_READ, S_RACK, S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      wr_q, wr_d;
  logic            rw_q, rw_d;
  logic            err_q, err_d;      // NACK seen during the running transaction
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ackerr_q, ackerr_d;
  logic [7:0]      rd_q, rd_d;
  logic            scl_q, scl_d;
  logic            sdal_q, sdal_d;    // 1 = pull SDA low
  logic            tick;
  logic            mid;

  assign tick = (state_q != S_IDLE) && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    wr_d     = wr_q;
    rw_d     = rw_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ackerr_d = ackerr_q;
    rd_d     = rd_q;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (i_start) begin
        state_d  = S_START;
        qtr_d    = 2'd0;
        bit_d    = 3'd0;
        sh_d     = {i_addr, i_rw};
        wr_d     = i_wrdata;
        rw_d     = i_rw;
        err_d    = 1'b0;
        ackerr_d = 1'b0;
        busy_d   = 1'b1;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        qtr_d = qtr_q + 2'd1;
        // End of q1 is the start of q2: SCL has been high a full quarter.
        if (qtr_q == 2'd1) begin
          case (state_q)
            S_AACK, S_WACK: if (io_sda) err_d = 1'b1;
            S_READ:         sh_d = {sh_q[6:0], io_sda};
            default: ;
          endcase
        end
        // End of q3: slot boundary.
        if (qtr_q == 2'd3) begin
          bit_d = bit_q + 3'd1;
          case (state_q)
            S_START: begin
              state_d = S_ADDR;
              bit_d   = 3'd0;
            end
            S_ADDR: begin
              sh_d = {sh_q[6:0], 1'b0};
              if (bit_q == 3'd7) state_d = S_AACK;
            end
            S_AACK: begin
              bit_d = 3'd0;
              if (err_q)     state_d = S_STOP;
              else if (rw_q) state_d = S_READ;
              else begin
                state_d = S_WRITE;
                sh_d    = wr_q;
              end
            end
            S_WRITE: begin
              sh_d = {sh_q[6:0], 1'b0};
              if (bit_q == 3'd7) state_d = S_WACK;
            end
            S_WACK:  state_d = S_STOP;
            S_READ:  if (bit_q == 3'd7) state_d = S_RACK;
            S_RACK:  state_d = S_STOP;
            S_STOP: begin
              state_d  = S_IDLE;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              ackerr_d = err_q;
              if (rw_q && !err_q) rd_d = sh_q;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    // Bus levels for the quarter being entered, so the pins are registered.
    mid = (qtr_d == 2'd1) || (qtr_d == 2'd2);
    case (state_d)
      S_IDLE: begin
        scl_d  = 1'b1;
        sdal_d = 1'b0;
      end
      S_START: begin
        scl_d  = (qtr_d != 2'd3);
        sdal_d = (qtr_d != 2'd0);
      end
      S_ADDR, S_WRITE: begin
        scl_d  = mid;
        sdal_d = ~sh_d[7];
      end
      S_STOP: begin
        scl_d  = (qtr_d != 2'd0);
        sdal_d = (qtr_d < 2'd2);
      end
      default: begin
        scl_d  = mid;
        sdal_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd0;
      sh_q     <= 8'h00;
      wr_q     <= 8'h00;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
      rd_q     <= 8'h00;
      scl_q    <= 1'b1;
      sdal_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ackerr_q <= ackerr_d;
      rd_q     <= rd_d;
      scl_q    <= scl_d;
      sdal_q   <= sdal_d;
    end
  end

  assign io_sda    = sdal_q ? 1'b0 : 1'bz;
  assign o_scl     = scl_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_ack_err = ackerr_q;
  assign o_rddata  = rd_q;

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: drives i2c_master with directed and random one-byte
// transactions. A bus-level slave/monitor decodes START/STOP and the bit
// sampled on every SCL rise, answers ACKs and read data, and checks SCL
// period; each test compares against a protocol-level expectation.
module tb_i2c_master;

  localparam int CD = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [6:0] i_addr = '0;
  logic       i_rw = 1'b0;
  logic [7:0] i_wrdata = '0;
  logic       o_scl, o_busy, o_done, o_ack_err;
  logic [7:0] o_rddata;
  wire        sda_bus;

  int total = 0;
  int bad = 0;

  // slave / monitor state
  logic       slv_en = 1'b0;
  logic       slv_drv = 1'b0;
  logic       cfg_aack = 1'b1;
  logic       cfg_dack = 1'b1;
  logic [7:0] cfg_rb = 8'h00;
  bit         bits_q[$];
  int         n_start = 0, n_stop = 0, per_err = 0;
  int         nrise = 0, cyc = 0, last_rise = -1;
  logic       p_scl = 1'b1, p_sda = 1'b1;
  logic [7:0] exp_rd = 8'h00;

  pullup (sda_bus);
  assign sda_bus = (slv_en && slv_drv) ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(CD)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_addr(i_addr),
    .i_rw(i_rw), .i_wrdata(i_wrdata), .o_scl(o_scl), .io_sda(sda_bus),
    .o_busy(o_busy), .o_done(o_done), .o_ack_err(o_ack_err), .o_rddata(o_rddata)
  );

  always #5 i_clk = ~i_clk;

  // Bus decoder + slave responder, sampled away from the active edge.
  always @(negedge i_clk) begin
    logic s, d, rwb;
    cyc++;
    s = o_scl;
    d = sda_bus;
    if (!slv_en) slv_drv = 1'b0;
    if (p_scl && s && p_sda && !d) begin
      n_start++;
      nrise = 0;
      last_rise = -1;
      slv_drv = 1'b0;
    end else if (p_scl && s && !p_sda && d) begin
      n_stop++;
    end
    if (!p_scl && s) begin
      nrise++;
      bits_q.push_back(d);
      if (last_rise >= 0 && (cyc - last_rise) != 4*CD) per_err++;
      last_rise = cyc;
    end
    if (p_scl && !s) begin
      rwb = (bits_q.size() >= 8) ? bits_q[7] : 1'b0;
      slv_drv = 1'b0;
      if (nrise == 8) slv_drv = cfg_aack;
      else if (nrise >= 9 && nrise <= 16 && cfg_aack && rwb) slv_drv = !cfg_rb[16-nrise];
      else if (nrise == 17 && cfg_aack && !rwb) slv_drv = cfg_dack;
    end
    p_scl = s;
    p_sda = d;
  end

  task automatic run_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic aack, input logic dack, input logic [7:0] rb,
                         input int glitch_at, input string tag);
    bit         exp_q[$];
    logic [7:0] ab, db;
    logic       exp_err;
    int         exp_lat, n, busy_gap;
    logic [31:0] gv, ev;
    // protocol-level expectation
    ab = {a, rw};
    for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
    exp_q.push_back(!aack);
    if (aack) begin
      db = rw ? rb : wd;
      for (int i = 7; i >= 0; i--) exp_q.push_back(db[i]);
      exp_q.push_back(rw ? 1'b1 : !dack);
    end
    exp_q.push_back(1'b0);           // SDA low on the STOP slot's SCL rise
    exp_err = !aack || (!rw && !dack);
    exp_lat = aack ? 80*CD : 44*CD;
    if (rw && !exp_err) exp_rd = rb;

    cfg_aack = aack; cfg_dack = dack; cfg_rb = rb;
    bits_q.delete();
    n_start = 0; n_stop = 0; per_err = 0;
    slv_en = 1'b1;

    @(negedge i_clk);
    i_addr = a; i_rw = rw; i_wrdata = wd; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin bad++; $display("FAIL %s busy_on_accept got=%b want=1", tag, o_busy); end

    n = 0; busy_gap = 0;
    while (n < 2000) begin
      @(posedge i_clk); #1;
      n++;
      if (n == glitch_at) begin
        i_start = 1'b1; i_addr = a ^ 7'h55; i_wrdata = ~wd; i_rw = !rw;
      end else i_start = 1'b0;
      if (o_done) break;
      if (!o_busy) busy_gap++;
    end

    total++;
    if (n != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", tag, n, exp_lat); end
    if (!o_done) return;
    total++;
    if (busy_gap != 0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL %s busy got_gaps=%0d busy_at_done=%b want 0/0", tag, busy_gap, o_busy);
    end
    total++;
    if (o_ack_err !== exp_err) begin bad++; $display("FAIL %s ack_err got=%b want=%b", tag, o_ack_err, exp_err); end
    total++;
    if (o_rddata !== exp_rd) begin bad++; $display("FAIL %s rddata got=%h want=%h", tag, o_rddata, exp_rd); end

    gv = '0; ev = '0;
    foreach (bits_q[i]) gv = {gv[30:0], bits_q[i]};
    foreach (exp_q[i]) ev = {ev[30:0], exp_q[i]};
    total++;
    if (bits_q.size() != exp_q.size() || gv !== ev)
      begin bad++; $display("FAIL %s bus_bits got=%0d:%h want=%0d:%h", tag, bits_q.size(), gv, exp_q.size(), ev); end
    total++;
    if (n_start != 1 || n_stop != 1)
      begin bad++; $display("FAIL %s start_stop got=%0d/%0d want=1/1", tag, n_start, n_stop); end
    total++;
    if (per_err != 0) begin bad++; $display("FAIL %s scl_period bad_periods=%0d want=0", tag, per_err); end

    @(posedge i_clk); #1;
    total++;
    if (o_done !== 1'b0 || o_ack_err !== exp_err)
      begin bad++; $display("FAIL %s done_pulse got done=%b err=%b want 0/%b", tag, o_done, o_ack_err, exp_err); end
    slv_en = 1'b0;
    repeat (3) @(posedge i_clk);
  endtask

  task automatic check_idle(input string tag);
    total++;
    if (o_scl !== 1'b1 || sda_bus !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_ack_err !== 1'b0 || o_rddata !== 8'h00) begin
      bad++;
      $display("FAIL %s idle got scl=%b sda=%b busy=%b done=%b err=%b rd=%h want 1/1/0/0/0/00",
               tag, o_scl, sda_bus, o_busy, o_done, o_ack_err, o_rddata);
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 check_idle("reset");
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
  endtask

  task automatic test_write();     run_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, -1, "write"); endtask
  task automatic test_read();      run_txn(7'h50, 1'b1, 8'h00, 1'b1, 1'b1, 8'h0B, -1, "read"); endtask
  task automatic test_addr_nack(); run_txn(7'h23, 1'b1, 8'h00, 1'b0, 1'b1, 8'h77, -1, "addr_nack"); endtask
  task automatic test_data_nack(); run_txn(7'h50, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00, -1, "data_nack"); endtask
  task automatic test_ignore_start(); run_txn(7'h2A, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00, 100, "busy_start"); endtask

  task automatic test_mid_reset();
    cfg_aack = 1'b1; cfg_rb = 8'h00; slv_en = 1'b1;
    bits_q.delete();
    @(negedge i_clk);
    i_addr = 7'h50; i_rw = 1'b1; i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    repeat (200) @(posedge i_clk);   // inside read data slot 3
    #1 slv_en = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check_idle("mid_reset");
    i_rst_n = 1'b1;
    exp_rd = 8'h00;
    repeat (4) @(posedge i_clk);
    run_txn(7'h11, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, -1, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      run_txn(7'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0), 8'($urandom), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_data_nack();
    test_ignore_start();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
